// File: rtl/event_coalesce_pkg.sv
// Shared definitions for the event coalescer.
// This file holds the FSM state encoding and the default counter and timer widths.
package event_coalesce_pkg;

  localparam int NE_DEFAULT = 16;
  localparam int NT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_PEND  = 2'd2
  } state_t;

endpackage

// File: rtl/event_coalesce_if.sv
// Signal bundle between the event/interrupt consumer (master) and the event coalescer (slave).
// The coalescer's FSM state is carried alongside the bundle for observation.
interface event_coalesce_if
  import event_coalesce_pkg::*;
#(
  parameter int NE = NE_DEFAULT,
  parameter int NT = NT_DEFAULT
);

  logic          enable;
  logic          event_in;
  logic [NE-1:0] threshold;
  logic [NT-1:0] timeout;
  // irq is a level request that stays high until irq_ack is seen high on a clock edge
  // while irq=1. irq_count is stable whenever irq=1. An irq_ack while irq=0 has no effect.
  logic          irq;
  logic [NE-1:0] irq_count;
  logic          irq_ack;
  logic          overflow;
  state_t        state;

  modport master (
    output enable, event_in, threshold, timeout, irq_ack,
    input  irq, irq_count, overflow, state
  );

  modport slave (
    input  enable, event_in, threshold, timeout, irq_ack,
    output irq, irq_count, overflow, state
  );

endinterface

// File: rtl/event_coalesce_timer.sv
// NT-bit saturating up-counter that measures clocks since the first pending event.
// The expired output compares against timeout, and timeout=0 means the timer never expires.
module event_coalesce_timer #(
  parameter int NT = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          run,
  input  logic [NT-1:0] timeout,
  output logic          expired
);

  logic [NT-1:0] value;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (run && (value != '1)) begin
      value <= value + NT'(1);
    end
  end

  // The comparison is one bit wider, so value+1 cannot wrap when value is saturated.
  assign expired = (timeout != '0) &&
                   (({1'b0, value} + (NT+1)'(1)) >= {1'b0, timeout});

endmodule

// File: rtl/event_coalesce.sv
// Coalesces single-cycle event pulses into one held level IRQ with a count snapshot.
// The timeout trigger exists only when EVENT_COALESCE_TIMEOUT_EN is defined; otherwise only the threshold raises the IRQ.
module event_coalesce
  import event_coalesce_pkg::*;
#(
  parameter int NE = NE_DEFAULT,
  parameter int NT = NT_DEFAULT
) (
  input logic             clock,
  input logic             reset_n,
  event_coalesce_if.slave bus
);

  localparam logic [NE-1:0] CNT_MAX = '1;

  state_t        state, state_next;
  logic [NE-1:0] count, count_next, count_inc;
  logic [NE-1:0] snap, snap_next;
  logic [NE-1:0] thr_eff;
  logic          ovf, ovf_next;
  logic          ev, ovf_set, thr_hit, tmo_hit, take_trig;

  assign ev        = bus.event_in & bus.enable;
  assign ovf_set   = ev && (count == CNT_MAX);
  assign count_inc = (ev && (count != CNT_MAX)) ? count + NE'(1) : count;
  assign thr_eff   = (bus.threshold == '0) ? NE'(1) : bus.threshold;
  assign thr_hit   = (count_inc >= thr_eff);

`ifdef EVENT_COALESCE_TIMEOUT_EN
  logic tmr_clear, tmr_run;

  // The timer restarts whenever a batch is closed. It counts only while a partial batch is live.
  assign tmr_clear = (state == ST_IDLE) || take_trig;
  assign tmr_run   = (state == ST_ACCUM) || ((state == ST_PEND) && (count != '0));

  event_coalesce_timer #(.NT(NT)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .run     (tmr_run),
    .timeout (bus.timeout),
    .expired (tmo_hit)
  );
`else
  logic [NT-1:0] timeout_unused;

  assign timeout_unused = bus.timeout;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_next = state;
    count_next = count_inc;
    snap_next  = snap;
    ovf_next   = ovf | ovf_set;
    take_trig  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev) begin
          if (thr_hit) begin
            take_trig  = 1'b1;
            state_next = ST_PEND;
          end else begin
            state_next = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (thr_hit || tmo_hit) begin
          take_trig  = 1'b1;
          state_next = ST_PEND;
        end
      end
      ST_PEND: begin
        // A trigger condition that is met while pending is handled in ACCUM after the acknowledge.
        if (bus.irq_ack) begin
          ovf_next   = ovf_set;
          state_next = (count_inc != '0) ? ST_ACCUM : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (take_trig) begin
      snap_next  = count_inc;
      count_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      count <= '0;
      snap  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      snap  <= snap_next;
      ovf   <= ovf_next;
    end
  end

  assign bus.irq       = (state == ST_PEND);
  assign bus.irq_count = snap;
  assign bus.overflow  = ovf;
  assign bus.state     = state;

endmodule
